sar_adc_ctrl: RTL

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

---
 rtl/sar_adc_pkg.sv | 17 +
 rtl/sar_bit_reg.sv | 64 ++++++
 rtl/sar_adc_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
// Shared definitions for the SAR ADC controller: FSM state encoding and
// default conversion parameters.
package sar_adc_pkg;

    localparam int NBITS_DEF      = 8;
    localparam int SAMPLE_CYC_DEF = 2;
    localparam int CNT_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CMP    = 3'd3,
        ST_DONE   = 3'd4
    } sar_state_t;

endpackage

// File: rtl/sar_bit_reg.sv
// Successive-approximation register: trial-bit pointer, code update from the
// comparator decision, and the sticky unresolved-decision flag.
module sar_bit_reg
    import sar_adc_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             load,
    input  logic             decide,
    input  logic             cmp_outp,
    input  logic             cmp_outn,
    output logic [NBITS-1:0] code,
    output logic             last,
    output logic [NBITS-1:0] code_nxt,
    output logic             err_nxt
);

    localparam int PW = $clog2(NBITS);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          err_flag;

    assign last = (ptr == '0);

    // A decision resolves bit ptr and, in the same edge, raises the next trial bit.
    always_comb begin
        code_nxt = code;
        ptr_nxt  = ptr;
        err_nxt  = err_flag;
        if (clr) begin
            code_nxt = '0;
            err_nxt  = 1'b0;
        end else if (load) begin
            code_nxt          = '0;
            code_nxt[NBITS-1] = 1'b1;
            ptr_nxt           = PW'(NBITS - 1);
        end else if (decide) begin
            code_nxt[ptr] = cmp_outp & ~cmp_outn;
            if (cmp_outp == cmp_outn)
                err_nxt = 1'b1;
            if (ptr != '0) begin
                code_nxt[ptr - 1'b1] = 1'b1;
                ptr_nxt              = ptr - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            code     <= '0;
            ptr      <= PW'(NBITS - 1);
            err_flag <= 1'b0;
        end else begin
            code     <= code_nxt;
            ptr      <= ptr_nxt;
            err_flag <= err_nxt;
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC conversion sequencer: sampling, per-bit settle/compare timing and
// result reporting; the code itself lives in sar_bit_reg.
//
// state  | meaning
// IDLE   | waiting for start, DAC code parked at zero
// SAMPLE | track-and-hold tracking for SAMPLE_CYC cycles
// SETTLE | DAC settling on the current trial code
// CMP    | comparator evaluating the current trial code
// DONE   | one-cycle result strobe
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int NBITS      = NBITS_DEF,
    parameter int SAMPLE_CYC = SAMPLE_CYC_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             cmp_outp,
    input  logic             cmp_outn,
    output logic             cmp_clk,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] result,
    output logic             err
);

    sar_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             clr;
    logic             load;
    logic             decide;
    logic             last;
    logic [NBITS-1:0] code_nxt;
    logic             err_nxt;

    // Leaving DONE always clears the code so dac_code reads zero in IDLE/SAMPLE.
    assign clr    = ((state == ST_IDLE) && start) || (state == ST_DONE);
    assign load   = (state == ST_SAMPLE) && (cnt == '0);
    assign decide = (state == ST_CMP);

    sar_bit_reg #(.NBITS(NBITS)) u_sar (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (clr),
        .load     (load),
        .decide   (decide),
        .cmp_outp (cmp_outp),
        .cmp_outn (cmp_outn),
        .code     (dac_code),
        .last     (last),
        .code_nxt (code_nxt),
        .err_nxt  (err_nxt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sample  <= 1'b0;
            cmp_clk <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state  <= ST_SAMPLE;
                        cnt    <= CNT_W'(SAMPLE_CYC - 1);
                        sample <= 1'b1;
                        busy   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt == '0) begin
                        state  <= ST_SETTLE;
                        sample <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    state   <= ST_CMP;
                    cmp_clk <= 1'b1;
                end
                ST_CMP: begin
                    cmp_clk <= 1'b0;
                    if (last) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= code_nxt;
                        err    <= err_nxt;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    sample  <= 1'b0;
                    cmp_clk <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
